// File: rtl/instr_decode_stage.sv
// Buffered instruction decode stage: full RV decode of each fetched word into a
// DEPTH-entry FIFO of decoded bundles, with registered in_ready and sync flush.
`timescale 1ns/1ps
module instr_decode_stage #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [6:0]         out_opcode,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [2:0]         out_funct3,
    output logic [6:0]         out_funct7,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int UP_W  = 12 - SHAMT_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    // upper shift-immediate bits for an arithmetic right shift (instr[30] set)
    localparam logic [UP_W-1:0]  SRA_UP  = UP_W'(1) << (UP_W - 2);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [SHAMT_W-1:0] shamt;
        logic [XLEN-1:0]    imm;
        logic               illegal;
    } bundle_t;

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [UP_W-1:0]    sh_up;
    logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [4:0]         d_rd, d_rs1, d_rs2;
    logic [2:0]         d_f3;
    logic [6:0]         d_f7;
    logic [SHAMT_W-1:0] d_sh;
    logic [XLEN-1:0]    d_imm;
    logic               legal;
    bundle_t            d_bundle;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign sh_up = in_instr[31:20+SHAMT_W];

    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

    always_comb begin
        d_rd  = '0;
        d_rs1 = '0;
        d_rs2 = '0;
        d_f3  = '0;
        d_f7  = '0;
        d_sh  = '0;
        d_imm = '0;
        legal = 1'b0;
        // every legal opcode ends in 2'b11, so the default arm also covers that check
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1;
                d_rd  = in_instr[11:7];
                d_imm = imm_u;
            end
            OPC_JAL: begin
                legal = 1'b1;
                d_rd  = in_instr[11:7];
                d_imm = imm_j;
            end
            OPC_JALR: begin
                legal = (f3 == 3'b000);
                d_rd  = in_instr[11:7];
                d_rs1 = in_instr[19:15];
                d_f3  = f3;
                d_imm = imm_i;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                d_rs1 = in_instr[19:15];
                d_rs2 = in_instr[24:20];
                d_f3  = f3;
                d_imm = imm_b;
            end
            OPC_LOAD: begin
                legal = (XLEN == 64) ? (f3 != 3'b111)
                                     : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                d_rd  = in_instr[11:7];
                d_rs1 = in_instr[19:15];
                d_f3  = f3;
                d_imm = imm_i;
            end
            OPC_STORE: begin
                legal = (XLEN == 64) ? (f3 <= 3'b011) : (f3 <= 3'b010);
                d_rs1 = in_instr[19:15];
                d_rs2 = in_instr[24:20];
                d_f3  = f3;
                d_imm = imm_s;
            end
            OPC_OP: begin
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                d_rd  = in_instr[11:7];
                d_rs1 = in_instr[19:15];
                d_rs2 = in_instr[24:20];
                d_f3  = f3;
                d_f7  = f7;
            end
            OPC_OPIMM: begin
                d_rd  = in_instr[11:7];
                d_rs1 = in_instr[19:15];
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    legal = (sh_up == '0) || ((sh_up == SRA_UP) && (f3 == 3'b101));
                    d_sh  = in_instr[20+SHAMT_W-1:20];
                    d_f7  = f7;
                end else begin
                    legal = 1'b1;
                    d_f3  = f3;
                    d_imm = imm_i;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            d_rd  = '0;
            d_rs1 = '0;
            d_rs2 = '0;
            d_f3  = '0;
            d_f7  = '0;
            d_sh  = '0;
            d_imm = '0;
        end
    end

    always_comb begin
        d_bundle         = '0;
        d_bundle.pc      = in_pc;
        d_bundle.opcode  = opc;
        d_bundle.rd      = d_rd;
        d_bundle.rs1     = d_rs1;
        d_bundle.rs2     = d_rs2;
        d_bundle.funct3  = d_f3;
        d_bundle.funct7  = d_f7;
        d_bundle.shamt   = d_sh;
        d_bundle.imm     = d_imm;
        d_bundle.illegal = ~legal;
    end

    bundle_t          mem [DEPTH];
    bundle_t          head;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             push, pop;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (pop && !push)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next < DEPTH_C);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // storage needs no reset: outputs are masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= d_bundle;
    end

    assign out_valid = (count != '0);
    assign head      = out_valid ? mem[rd_ptr] : '0;

    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_shamt   = head.shamt;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Parametrised, buffered successor to the combinational pre-decoder. It accepts fetched instructions over a valid/ready handshake and fully decodes each one into register addresses, function fields and a sign-extended immediate, including a legality check. Decoded bundles are held in a DEPTH-entry FIFO, so the decode stage can absorb execute-stage stalls without a combinational ready path. It sits between instruction fetch and the register-file read / execute stage.

## Interface
- XLEN, 32: datapath width; 32 or 64; sets pc/imm width.
- DEPTH, 2: decoded-bundle FIFO entries; power of 2, ≥2.
- SHAMT_W, (XLEN==64 ? 6 : 5): shift-amount width, taken from instr[20+SHAMT_W-1:20].

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept (registered).
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard all buffered and incoming instructions.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  consumer takes head.
- out_pc  out  XLEN  pc of head.
- out_opcode  out  7  instr[6:0].
- out_rd / out_rs1 / out_rs2  out  5 each  register addresses (0 when unused).
- out_funct3  out  3; out_funct7  out  7; out_shamt  out  SHAMT_W.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  instruction failed legality check.

## Operation
- Push when in_valid && in_ready && !flush; pop when out_valid && out_ready.
- Decode is combinational on in_instr; the FIFO stores the decoded bundle. Decode is never re-run at the output.
- Field rules per opcode:
  - LUI/AUIPC: rd, imm = {instr[31:12],12'b0} sign-extended to XLEN.
  - JAL: rd, J-imm.
  - JALR: rd, rs1, funct3, I-imm.
  - BRANCH: rs1, rs2, funct3, B-imm; rd=0.
  - STORE: rs1, rs2, funct3, S-imm **sign-extended**; rd=0.
  - LOAD: rd, rs1, funct3, I-imm.
  - OP: rd, rs1, rs2, funct3, funct7; imm=0.
  - OP-IMM shifts (funct3 001/101): rd, rs1, shamt, funct7; imm=0.
  - Other OP-IMM: rd, rs1, funct3, I-imm.
  - Fields unused by a format are 0.
- out_illegal=1 for any of:
  - instr[1:0]≠11;
  - unknown opcode;
  - BRANCH funct3 010/011;
  - LOAD funct3 outside {000,001,010,100,101} (XLEN=32) or 111 (XLEN=64);
  - STORE funct3 >010 (XLEN=32) or >011 (XLEN=64);
  - OP funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000,101};
  - OP-IMM shift with upper funct7 bits (above the shamt) not 0 / 0100000 as for OP;
  - JALR funct3≠000.
- For an illegal instruction: all decoded fields are 0, out_illegal=1, out_pc and out_opcode are retained.
- Storage: rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits).
- in_ready_next = (count_next < DEPTH). No same-cycle pop-to-ready path: when full, a simultaneous pop does not allow a push that cycle.
- out_* data fields read from the head entry and are forced to 0 when out_valid=0.
- flush is synchronous and has priority: next edge count=0, pointers=0, in_ready=1. A push or pop offered in the flush cycle is discarded.

## Timing
- While rst_n=0: out_valid=0, in_ready=0, count/pointers=0, all out data fields 0.
- First rising edge after rst_n rises: in_ready=1.
- Latency: an instruction pushed at edge N is at the output (out_valid=1) after edge N, even if the FIFO was empty. Throughput is 1 instruction/cycle with DEPTH≥2 and out_ready held high.
- Simultaneous push and pop with count between 1 and DEPTH-1: count is unchanged and ordering is preserved.
- Output data stays stable while out_valid=1 && out_ready=0.
- Asserting rst_n mid-stream empties the FIFO immediately (asynchronous); contents are lost.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, in_ready=0, out_imm=0. Release → in_ready=1 after the first edge; no phantom entry.
- addi x5,x1,-1 (0xFFF08293), pc=0x100, out_ready=1 → next cycle out_valid=1, rd=5, rs1=1, rs2=0, funct3=0, imm=0xFFFFFFFF, illegal=0, out_pc=0x100.
- sw x2,-4(x1) (0xFE20AE23) → rs1=1, rs2=2, rd=0, funct3=010, imm=0xFFFFFFFC. Also srai x3,x4,2 (0x40225193) → shamt=2, funct7=0100000, imm=0.
- Backpressure: out_ready=0, push 4 instructions with DEPTH=2 → in_ready drops after 2 accepted. Then out_ready=1 → outputs drain in order, in_ready returns to 1, the un-accepted pair is re-offered and taken.
- Flush: FIFO full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, count=0; the offered instruction never appears.
- Illegal: 0x00000000 and 0x40209133 (sll with funct7 0100000) → out_illegal=1, rd/rs1/rs2/imm=0, pc retained.
